rx_deserializer: RTL and testbench

RX_DESERIALIZER -- requirements
Module: rx_deserializer

---
 rtl/rx_deserializer.sv | 242 ++++++++++++++++++++++++
 tb/tb_rx_deserializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deserializer.sv
// rx_deserializer
//   UART receive deserializer. Oversamples the asynchronous rx line on baud
//   ticks, assembles 8 data bits (optionally followed by a parity bit and
//   always by one stop bit) and writes each good byte into an external FIFO.
//
// Ports
//   clk            system clock, all state changes on rising edge
//   rst            asynchronous active-high reset
//   p_BaudSig_i    oversample tick, one clk wide, OVERSAMPLE ticks per bit
//   SerialData_i   asynchronous rx line, idle high
//   p_BigEnd_i     1 = first data bit is bit7, 0 = first data bit is bit0
//   p_ParityEn_i   1 = a parity bit follows the data bits
//   p_ParityOdd_i  1 = odd parity, 0 = even parity
//   p_FifoFull_i   rx FIFO full
//   n_FifoWe_o     FIFO write strobe, active low, one clk wide
//   FifoData_o     received byte, held until the next good frame
//   p_ParityErr_o  one-clk pulse on parity mismatch
//   p_FrameErr_o   one-clk pulse when the stop bit is sampled low
//   p_Overrun_o    one-clk pulse when a good frame is dropped (FIFO full)
//   State_o        current FSM state, one-hot
module rx_deserializer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       p_BaudSig_i,
   input  logic       SerialData_i,
   input  logic       p_BigEnd_i,
   input  logic       p_ParityEn_i,
   input  logic       p_ParityOdd_i,
   input  logic       p_FifoFull_i,
   output logic       n_FifoWe_o,
   output logic [7:0] FifoData_o,
   output logic       p_ParityErr_o,
   output logic       p_FrameErr_o,
   output logic       p_Overrun_o,
   output logic [4:0] State_o
);

   localparam logic [4:0] IDLE      = 5'b0_0001;
   localparam logic [4:0] STARTBIT  = 5'b0_0010;
   localparam logic [4:0] DATABITS  = 5'b0_0100;
   localparam logic [4:0] PARITYBIT = 5'b0_1000;
   localparam logic [4:0] STOPBIT   = 5'b1_0000;

   localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       line_prev_q, line_prev_d;
   logic [4:0] state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] bit_q, bit_d;
   logic       armed_q, armed_d;
   logic       big_q, big_d;
   logic       par_en_q, par_en_d;
   logic       odd_q, odd_d;
   logic       par_acc_q, par_acc_d;
   logic       par_err_q, par_err_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       n_we_q, n_we_d;
   logic       perr_q, perr_d;
   logic       ferr_q, ferr_d;
   logic       ovr_q, ovr_d;
   logic       line_s;
   logic [2:0] pos_s;

   assign line_s = sync2_q;

   // Next-state logic: synchronizer, FSM, counters, byte assembly and result pulses.
   always_comb begin
      sync1_d     = SerialData_i;
      sync2_d     = sync1_q;
      line_prev_d = line_s;
      state_d     = state_q;
      bit_d       = bit_q;
      armed_d     = armed_q;
      big_d       = big_q;
      par_en_d    = par_en_q;
      odd_d       = odd_q;
      par_acc_d   = par_acc_q;
      par_err_d   = par_err_q;
      shift_d     = shift_q;
      data_d      = data_q;
      n_we_d      = 1'b1;
      perr_d      = 1'b0;
      ferr_d      = 1'b0;
      ovr_d       = 1'b0;
      // Byte position of the bit currently being received.
      if (big_q) begin
         pos_s = 3'd7 - bit_q;
      end else begin
         pos_s = bit_q;
      end
      if (p_BaudSig_i) begin
         tick_d = tick_q + 4'd1;
      end else begin
         tick_d = tick_q;
      end

      case (state_q)
         IDLE: begin
            // Re-arm only after the line has been seen high on a tick, so a
            // line stuck low after a framing error cannot start a frame.
            if (p_BaudSig_i && line_s) begin
               armed_d = 1'b1;
            end else begin
               armed_d = armed_q;
            end
            if (line_prev_q && !line_s && armed_q) begin
               state_d   = STARTBIT;
               tick_d    = 4'd0;
               bit_d     = 3'd0;
               big_d     = p_BigEnd_i;
               par_en_d  = p_ParityEn_i;
               odd_d     = p_ParityOdd_i;
               par_acc_d = 1'b0;
               par_err_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         STARTBIT: begin
            if (p_BaudSig_i && (tick_q == MID_TICK)) begin
               tick_d = 4'd0;
               if (!line_s) begin
                  state_d = DATABITS;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = STARTBIT;
            end
         end
         DATABITS: begin
            if (p_BaudSig_i && (tick_q == LAST_TICK)) begin
               tick_d         = 4'd0;
               shift_d[pos_s] = line_s;
               par_acc_d      = par_acc_q ^ line_s;
               bit_d          = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  if (par_en_q) begin
                     state_d = PARITYBIT;
                  end else begin
                     state_d = STOPBIT;
                  end
               end else begin
                  state_d = DATABITS;
               end
            end else begin
               state_d = DATABITS;
            end
         end
         PARITYBIT: begin
            if (p_BaudSig_i && (tick_q == LAST_TICK)) begin
               tick_d    = 4'd0;
               par_err_d = par_acc_q ^ line_s ^ odd_q;
               state_d   = STOPBIT;
            end else begin
               state_d = PARITYBIT;
            end
         end
         STOPBIT: begin
            if (p_BaudSig_i && (tick_q == LAST_TICK)) begin
               tick_d  = 4'd0;
               state_d = IDLE;
               if (!line_s) begin
                  ferr_d  = 1'b1;
                  armed_d = 1'b0;
               end else begin
                  perr_d = par_err_q;
                  if (p_FifoFull_i) begin
                     ovr_d = 1'b1;
                  end else begin
                     n_we_d = 1'b0;
                     data_d = shift_q;
                  end
               end
            end else begin
               state_d = STOPBIT;
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = 4'd0;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         line_prev_q <= 1'b1;
         state_q     <= IDLE;
         tick_q      <= 4'd0;
         bit_q       <= 3'd0;
         armed_q     <= 1'b0;
         big_q       <= 1'b0;
         par_en_q    <= 1'b0;
         odd_q       <= 1'b0;
         par_acc_q   <= 1'b0;
         par_err_q   <= 1'b0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         n_we_q      <= 1'b1;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         line_prev_q <= line_prev_d;
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         armed_q     <= armed_d;
         big_q       <= big_d;
         par_en_q    <= par_en_d;
         odd_q       <= odd_d;
         par_acc_q   <= par_acc_d;
         par_err_q   <= par_err_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         n_we_q      <= n_we_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
      end
   end

   assign n_FifoWe_o    = n_we_q;
   assign FifoData_o    = data_q;
   assign p_ParityErr_o = perr_q;
   assign p_FrameErr_o  = ferr_q;
   assign p_Overrun_o   = ovr_q;
   assign State_o       = state_q;

endmodule

// File: tb/tb_rx_deserializer.sv
// tb_rx_deserializer
//   Directed bench for rx_deserializer (OVERSAMPLE = 16, one baud tick every
//   4 clks, so one bit period = 64 clks). Output pulses are counted by a
//   monitor; each scenario compares count deltas and the written byte
//   against hand-computed values.
module tb_rx_deserializer;

   localparam int BIT_CLKS = 64;

   logic       clk;
   logic       rst;
   logic       p_BaudSig_i;
   logic       SerialData_i;
   logic       p_BigEnd_i;
   logic       p_ParityEn_i;
   logic       p_ParityOdd_i;
   logic       p_FifoFull_i;
   logic       n_FifoWe_o;
   logic [7:0] FifoData_o;
   logic       p_ParityErr_o;
   logic       p_FrameErr_o;
   logic       p_Overrun_o;
   logic [4:0] State_o;

   int n_tests = 0;
   int n_fail  = 0;

   int we_cnt = 0, perr_cnt = 0, perr_we_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
   logic [7:0] last_data = 8'h00;
   int we0, perr0, perr_we0, ferr0, ovr0;

   rx_deserializer #(.OVERSAMPLE(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .p_BaudSig_i   (p_BaudSig_i),
      .SerialData_i  (SerialData_i),
      .p_BigEnd_i    (p_BigEnd_i),
      .p_ParityEn_i  (p_ParityEn_i),
      .p_ParityOdd_i (p_ParityOdd_i),
      .p_FifoFull_i  (p_FifoFull_i),
      .n_FifoWe_o    (n_FifoWe_o),
      .FifoData_o    (FifoData_o),
      .p_ParityErr_o (p_ParityErr_o),
      .p_FrameErr_o  (p_FrameErr_o),
      .p_Overrun_o   (p_Overrun_o),
      .State_o       (State_o)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Baud tick: one clk wide, every 4th clk.
   initial begin
      p_BaudSig_i = 1'b0;
      forever begin
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            p_BaudSig_i = (i == 3);
         end
      end
   end

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (n_FifoWe_o == 1'b0) begin
            we_cnt    <= we_cnt + 1;
            last_data <= FifoData_o;
         end
         if (p_ParityErr_o) perr_cnt <= perr_cnt + 1;
         if (p_ParityErr_o && !n_FifoWe_o) perr_we_cnt <= perr_we_cnt + 1;
         if (p_FrameErr_o) ferr_cnt <= ferr_cnt + 1;
         if (p_Overrun_o) ovr_cnt <= ovr_cnt + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      SerialData_i = b;
      wait_clks(BIT_CLKS);
   endtask

   task automatic snap();
      we0 = we_cnt; perr0 = perr_cnt; perr_we0 = perr_we_cnt;
      ferr0 = ferr_cnt; ovr0 = ovr_cnt;
   endtask

   // Start bit, d[0] first, optional parity bit, stop bit, then one idle bit.
   task automatic send_frame(input logic [7:0] d, input logic par_en,
                             input logic par_bit, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (par_en) drive_bit(par_bit);
      drive_bit(stop_bit);
      if (stop_bit) drive_bit(1'b1);
   endtask

   task automatic check_deltas(input string tag, input int we, input int perr,
                               input int ferr, input int ovr);
      check_eq({tag, "_we"},   32'(we_cnt - we0),     32'(we));
      check_eq({tag, "_perr"}, 32'(perr_cnt - perr0), 32'(perr));
      check_eq({tag, "_ferr"}, 32'(ferr_cnt - ferr0), 32'(ferr));
      check_eq({tag, "_ovr"},  32'(ovr_cnt - ovr0),   32'(ovr));
   endtask

   initial begin
      rst = 1'b1;
      SerialData_i = 1'b1;
      p_BigEnd_i = 1'b0; p_ParityEn_i = 1'b0; p_ParityOdd_i = 1'b0;
      p_FifoFull_i = 1'b0;
      wait_clks(5);
      check_eq("rst_state", 32'(State_o), 32'h01);
      check_eq("rst_we",    32'(n_FifoWe_o), 32'h1);
      check_eq("rst_data",  32'(FifoData_o), 32'h00);
      check_eq("rst_errs",  32'({p_ParityErr_o, p_FrameErr_o, p_Overrun_o}), 32'h0);
      rst = 1'b0;
      wait_clks(2 * BIT_CLKS);

      // 8N1 little-endian A5.
      snap();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      check_deltas("a5_le", 1, 0, 0, 0);
      check_eq("a5_le_data", 32'(last_data), 32'hA5);
      check_eq("a5_le_hold", 32'(FifoData_o), 32'hA5);
      check_eq("a5_le_idle", 32'(State_o), 32'h01);

      // Big-endian: A5 is a bit-palindrome, 01 becomes 80.
      p_BigEnd_i = 1'b1;
      snap();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      check_deltas("a5_be", 1, 0, 0, 0);
      check_eq("a5_be_data", 32'(last_data), 32'hA5);
      snap();
      send_frame(8'h01, 1'b0, 1'b0, 1'b1);
      check_deltas("01_be", 1, 0, 0, 0);
      check_eq("01_be_data", 32'(last_data), 32'h80);
      p_BigEnd_i = 1'b0;

      // Even parity: 03 has two ones, parity bit 1 is wrong, 0 is right.
      p_ParityEn_i = 1'b1;
      snap();
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      check_deltas("par_bad", 1, 1, 0, 0);
      check_eq("par_bad_data", 32'(last_data), 32'h03);
      check_eq("par_bad_same_clk", 32'(perr_we_cnt - perr_we0), 32'd1);
      snap();
      send_frame(8'h03, 1'b1, 1'b0, 1'b1);
      check_deltas("par_ok", 1, 0, 0, 0);
      // Odd parity: 03 with parity bit 1 is correct.
      p_ParityOdd_i = 1'b1;
      snap();
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      check_deltas("par_odd", 1, 0, 0, 0);
      p_ParityEn_i = 1'b0; p_ParityOdd_i = 1'b0;

      // Framing error on 55, line held low, then recovery with 33.
      snap();
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      wait_clks(2 * BIT_CLKS);
      check_deltas("ferr", 0, 0, 1, 0);
      check_eq("ferr_idle", 32'(State_o), 32'h01);
      check_eq("ferr_data_held", 32'(FifoData_o), 32'h03);
      SerialData_i = 1'b1;
      wait_clks(BIT_CLKS);
      snap();
      send_frame(8'h33, 1'b0, 1'b0, 1'b1);
      check_deltas("rec33", 1, 0, 0, 0);
      check_eq("rec33_data", 32'(last_data), 32'h33);

      // Glitch low for 3 ticks: false start, nothing reported.
      snap();
      SerialData_i = 1'b0;
      wait_clks(12);
      SerialData_i = 1'b1;
      wait_clks(2 * BIT_CLKS);
      check_deltas("glitch", 0, 0, 0, 0);
      check_eq("glitch_idle", 32'(State_o), 32'h01);

      // FIFO full: overrun pulse, no write.
      p_FifoFull_i = 1'b1;
      snap();
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      check_deltas("ovr", 0, 0, 0, 1);
      check_eq("ovr_data_held", 32'(FifoData_o), 32'h33);
      p_FifoFull_i = 1'b0;

      // Reset during data bit 4 aborts the frame.
      snap();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      check_eq("mid_databits", 32'(State_o), 32'h04);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_state", 32'(State_o), 32'h01);
      check_eq("mid_rst_data", 32'(FifoData_o), 32'h00);
      wait_clks(3);
      rst = 1'b0;
      SerialData_i = 1'b1;
      wait_clks(2 * BIT_CLKS);
      check_deltas("abort", 0, 0, 0, 0);
      snap();
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      check_deltas("c3", 1, 0, 0, 0);
      check_eq("c3_data", 32'(last_data), 32'hC3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
